lbm_step_scheduler: RTL and testbench

- Top-level sequencer for the D2Q9 LBM collide/stream datapath.
- Initialises the distribution memory, then issues every grid node once per timestep to the datapath, with a credit limit on in-flight nodes.
- Counts datapath write-backs to detect end of step, swaps ping-pong banks, and repeats for MAX_TIME steps before asserting FINISHED.

---
 rtl/lbm_pkg.sv | 20 ++
 rtl/lbm_credit_counter.sv | 51 +++++
 rtl/lbm_step_scheduler.sv | 141 ++++++++++++++
 tb/tb_lbm_step_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbm_pkg.sv
// Shared definitions for the D2Q9 LBM collide/stream datapath and its step scheduler.
package lbm_pkg;

  localparam int GRID_DIM        = 256;
  localparam int MAX_TIME        = 100;
  localparam int DATA_WIDTH      = 32;
  localparam int FRACTIONAL_BITS = 24;
  // Nine distribution functions per node, packed side by side.
  localparam int DATA_WIDTH_F    = 9 * DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    DRAIN,
    SWAP,
    DONE
  } state_t;

endpackage

// File: rtl/lbm_credit_counter.sv
// Outstanding-node credit counter: counts issued-but-not-written-back nodes.
// A write-back with nothing outstanding saturates at zero and raises a sticky
// underflow flag instead of wrapping.
module lbm_credit_counter #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int COUNT_WIDTH     = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_inc,
  input  logic                   i_dec,
  input  logic                   i_err_set,
  input  logic                   i_err_clr,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_dec_accepted,
  output logic                   o_underflow
);

  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_underflow;
  logic                   w_dec_at_zero;

  // A simultaneous issue covers the write-back, so only a lone decrement at zero underflows.
  assign w_dec_at_zero  = i_dec && !i_inc && (r_count == '0);
  assign o_dec_accepted = i_dec && !w_dec_at_zero;
  assign o_count        = r_count;
  assign o_underflow    = r_underflow;

  // Up/down count; an increment and decrement together cancel out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && !i_dec) begin
      r_count <= r_count + COUNT_WIDTH'(1);
    end else if (i_dec && !i_inc && !w_dec_at_zero) begin
      r_count <= r_count - COUNT_WIDTH'(1);
    end
  end

  // Sticky error flag; clear wins over a set arriving in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_underflow <= 1'b0;
    end else if (i_err_clr) begin
      r_underflow <= 1'b0;
    end else if (w_dec_at_zero || i_err_set) begin
      r_underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/lbm_step_scheduler.sv
// Top-level sequencer: initialises the distribution memory, issues every node
// once per timestep under a credit limit, detects end of step from write-backs,
// swaps the ping-pong banks and repeats for MAX_TIME steps.
module lbm_step_scheduler
  import lbm_pkg::*;
#(
  parameter int GRID_DIM         = lbm_pkg::GRID_DIM,
  parameter int MAX_TIME         = lbm_pkg::MAX_TIME,
  parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME),
  parameter int ADDRESS_WIDTH    = $clog2(GRID_DIM),
  parameter int MAX_OUTSTANDING  = 16,
  parameter int AUTO_START       = 1
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET,
  input  logic                        start,
  output logic                        init_en,
  output logic [ADDRESS_WIDTH-1:0]    init_addr,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [ADDRESS_WIDTH-1:0]    issue_addr,
  input  logic                        wb_valid,
  output logic                        rd_bank,
  output logic [TIME_COUNT_WIDTH-1:0] time_step,
  output logic                        busy,
  output logic                        FINISHED,
  output logic                        err_underflow
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDRESS_WIDTH-1:0]    LAST_ADDR = ADDRESS_WIDTH'(GRID_DIM - 1);
  localparam logic [ADDRESS_WIDTH:0]      NODE_CNT  = (ADDRESS_WIDTH + 1)'(GRID_DIM);
  localparam logic [TIME_COUNT_WIDTH-1:0] LAST_TIME = TIME_COUNT_WIDTH'(MAX_TIME - 1);
  localparam logic [CW-1:0]               CREDITS   = CW'(MAX_OUTSTANDING);

  state_t                        r_state;
  state_t                        w_state_next;
  logic [ADDRESS_WIDTH-1:0]      r_init_addr;
  logic [ADDRESS_WIDTH-1:0]      r_issue_addr;
  logic [ADDRESS_WIDTH:0]        r_wb_count;
  logic [ADDRESS_WIDTH:0]        w_wb_count_next;
  logic [TIME_COUNT_WIDTH-1:0]   r_time_step;
  logic                          r_rd_bank;
  logic [CW-1:0]                 w_credit;
  logic                          w_issue_valid;
  logic                          w_handshake;
  logic                          w_wb_window;
  logic                          w_wb_dec;
  logic                          w_wb_stray;
  logic                          w_wb_accepted;
  logic                          w_restart;
  logic                          w_err_underflow;

  assign w_issue_valid   = (r_state == RUN) && (w_credit < CREDITS);
  assign w_handshake     = w_issue_valid && issue_ready;
  assign w_wb_window     = (r_state == RUN) || (r_state == DRAIN);
  assign w_wb_dec        = wb_valid && w_wb_window;
  assign w_wb_stray      = wb_valid && !w_wb_window;
  assign w_restart       = (r_state == DONE) && start;
  // Look-ahead count lets DRAIN leave in the same cycle the last write-back lands.
  assign w_wb_count_next = r_wb_count + {{ADDRESS_WIDTH{1'b0}}, w_wb_accepted};

  lbm_credit_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .COUNT_WIDTH    (CW)
  ) u_credit (
    .i_clk         (CLOCK_50),
    .i_rst_n       (RESET),
    .i_inc         (w_handshake),
    .i_dec         (w_wb_dec),
    .i_err_set     (w_wb_stray),
    .i_err_clr     (w_restart),
    .o_count       (w_credit),
    .o_dec_accepted(w_wb_accepted),
    .o_underflow   (w_err_underflow)
  );

  // State register.
  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start || (AUTO_START != 0)) w_state_next = INIT;
      INIT:    if (r_init_addr == LAST_ADDR) w_state_next = RUN;
      RUN:     if (w_handshake && (r_issue_addr == LAST_ADDR)) w_state_next = DRAIN;
      DRAIN:   if (w_wb_count_next == NODE_CNT) w_state_next = SWAP;
      SWAP:    w_state_next = (r_time_step == LAST_TIME) ? DONE : RUN;
      DONE:    if (start) w_state_next = INIT;
      default: w_state_next = IDLE;
    endcase
  end

  // Address, write-back, timestep and bank bookkeeping.
  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      r_init_addr  <= '0;
      r_issue_addr <= '0;
      r_wb_count   <= '0;
      r_time_step  <= '0;
      r_rd_bank    <= 1'b0;
    end else begin
      if (r_state == INIT) begin
        r_init_addr <= (r_init_addr == LAST_ADDR) ? '0 : r_init_addr + ADDRESS_WIDTH'(1);
        if (r_init_addr == LAST_ADDR) begin
          r_time_step <= '0;
          r_rd_bank   <= 1'b0;
        end
      end
      // The last address is held through DRAIN so the counter never wraps mid-step.
      if (w_handshake && (r_issue_addr != LAST_ADDR)) r_issue_addr <= r_issue_addr + ADDRESS_WIDTH'(1);
      if (r_state == SWAP) begin
        r_issue_addr <= '0;
        r_wb_count   <= '0;
        r_rd_bank    <= ~r_rd_bank;
        if (r_time_step != LAST_TIME) r_time_step <= r_time_step + TIME_COUNT_WIDTH'(1);
      end else begin
        r_wb_count <= w_wb_count_next;
      end
      if (w_restart) begin
        r_time_step <= '0;
        r_rd_bank   <= 1'b0;
      end
    end
  end

  assign init_en       = (r_state == INIT);
  assign init_addr     = r_init_addr;
  assign issue_valid   = w_issue_valid;
  assign issue_addr    = r_issue_addr;
  assign rd_bank       = r_rd_bank;
  assign time_step     = r_time_step;
  assign busy          = (r_state == INIT) || (r_state == RUN) || (r_state == DRAIN) || (r_state == SWAP);
  assign FINISHED      = (r_state == DONE);
  assign err_underflow = w_err_underflow;

endmodule

// File: tb/tb_lbm_step_scheduler.sv
// Scoreboard bench for lbm_step_scheduler: a stimulus thread queues the expected
// init/issue sequence for each run, a driver models the datapath, and a monitor
// compares every init write, issue handshake and flag against a node-level model.
module tb_lbm_step_scheduler;

  localparam int G  = 16;
  localparam int T  = 3;
  localparam int MO = 4;
  localparam int AW = $clog2(G);
  localparam int TW = $clog2(T);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          issue_ready = 1'b0;
  logic          wb_valid = 1'b0;
  logic          init_en;
  logic [AW-1:0] init_addr;
  logic          issue_valid;
  logic [AW-1:0] issue_addr;
  logic          rd_bank;
  logic [TW-1:0] time_step;
  logic          busy;
  logic          finished;
  logic          err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lbm_step_scheduler #(
    .GRID_DIM       (G),
    .MAX_TIME       (T),
    .MAX_OUTSTANDING(MO),
    .AUTO_START     (1)
  ) dut (
    .CLOCK_50     (clk),
    .RESET        (rst_n),
    .start        (start),
    .init_en      (init_en),
    .init_addr    (init_addr),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_addr   (issue_addr),
    .wb_valid     (wb_valid),
    .rd_bank      (rd_bank),
    .time_step    (time_step),
    .busy         (busy),
    .FINISHED     (finished),
    .err_underflow(err)
  );

  typedef struct {
    int t;
    int bank;
    int addr;
  } issue_t;

  int     exp_init[$];
  issue_t exp_issue[$];

  typedef enum int {M_IDEAL, M_HOLD, M_BP} mode_t;
  mode_t mode = M_IDEAL;
  bit    pulse_req = 1'b0;

  // Monitor-owned model state.
  int model_out = 0;
  int issued = 0;
  int last_ts = 0;
  int busy_cycles = 0;
  bit exp_err = 1'b0;
  bit m_hs = 1'b0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // One run = G init writes, then every node of every step in order, bank alternating.
  function automatic void push_run();
    issue_t e;
    for (int a = 0; a < G; a++) exp_init.push_back(a);
    for (int t = 0; t < T; t++) begin
      for (int a = 0; a < G; a++) begin
        e.t = t; e.bank = t % 2; e.addr = a;
        exp_issue.push_back(e);
      end
    end
  endfunction

  // Datapath model: drives ready and write-backs just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        M_IDEAL: begin
          issue_ready = 1'b1;
          wb_valid    = m_hs;
        end
        M_HOLD: begin
          issue_ready = 1'b1;
          wb_valid    = pulse_req;
          pulse_req   = 1'b0;
        end
        default: begin
          issue_ready = ~issue_ready;
          wb_valid    = (model_out > 0) && ($urandom_range(0, 1) == 1);
        end
      endcase
    end
  end

  // Monitor: samples on the falling edge and compares against the model.
  initial begin
    bit     hs;
    bit     in_run;
    bit     wb_ok;
    int     ia;
    issue_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_out = 0; issued = 0; last_ts = 0; busy_cycles = 0;
        exp_err = 1'b0; m_hs = 1'b0;
        continue;
      end
      hs   = issue_valid && issue_ready;
      m_hs = hs;
      check("err_underflow", int'(err), int'(exp_err));
      if (busy) busy_cycles++;
      if (int'(time_step) != last_ts) begin
        issued  = 0;
        last_ts = int'(time_step);
      end
      in_run = busy && !init_en && (issued < G);
      check("issue_valid", int'(issue_valid), int'(in_run && (model_out < MO)));
      if (in_run) check("issue_addr_next", int'(issue_addr), issued);
      if (init_en) begin
        if (exp_init.size() == 0) begin
          check("init_unexpected", 1, 0);
        end else begin
          ia = exp_init.pop_front();
          check("init_addr", int'(init_addr), ia);
        end
      end
      if (hs) begin
        if (exp_issue.size() == 0) begin
          check("issue_unexpected", 1, 0);
        end else begin
          e = exp_issue.pop_front();
          checks++;
          if (int'(issue_addr) != e.addr || int'(time_step) != e.t || int'(rd_bank) != e.bank) begin
            errors++;
            $display("FAIL issue actual t=%0d bank=%0d addr=%0d expected t=%0d bank=%0d addr=%0d",
                     time_step, rd_bank, issue_addr, e.t, e.bank, e.addr);
          end
        end
        issued++;
      end
      wb_ok = 1'b0;
      if (wb_valid) begin
        if (!busy || init_en)        exp_err = 1'b1;
        else if (model_out == 0 && !hs) exp_err = 1'b1;
        else                         wb_ok = 1'b1;
      end
      model_out = model_out + (hs ? 1 : 0) - (wb_ok ? 1 : 0);
      if (start && finished) exp_err = 1'b0;
    end
  end

  task automatic wait_finished(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (finished) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_init_en"}, int'(init_en), 0);
    check({tag, "_init_addr"}, int'(init_addr), 0);
    check({tag, "_issue_valid"}, int'(issue_valid), 0);
    check({tag, "_issue_addr"}, int'(issue_addr), 0);
    check({tag, "_rd_bank"}, int'(rd_bank), 0);
    check({tag, "_time_step"}, int'(time_step), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_finished"}, int'(finished), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  task automatic check_run_end(input string tag, input bit check_cycles);
    bit ok;
    wait_finished(3000, ok);
    check({tag, "_finished"}, int'(ok), 1);
    if (check_cycles) check({tag, "_busy_cycles"}, busy_cycles, G + T * (G + 2));
    check({tag, "_time_step"}, int'(time_step), T - 1);
    check({tag, "_rd_bank"}, int'(rd_bank), T % 2);
    check({tag, "_init_left"}, exp_init.size(), 0);
    check({tag, "_issue_left"}, exp_issue.size(), 0);
  endtask

  // Stimulus sequence.
  initial begin
    bit found;

    // Run 1: reset, auto-start, ideal one-cycle datapath.
    push_run();
    #8;
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    check_run_end("run1", 1'b1);

    // Stray write-back while DONE sets the sticky error.
    @(negedge clk);
    #2 mode = M_HOLD;
    pulse_req = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("stray_wb_err_held", int'(err), 1);

    // Run 2: restart from DONE, then credit limit with write-backs withheld.
    push_run();
    pulse_start();
    @(negedge clk);
    #1;
    check("restart_err_clear", int'(err), 0);
    check("restart_finished", int'(finished), 0);
    check("restart_init_en", int'(init_en), 1);
    check("restart_time_step", int'(time_step), 0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (issued >= MO) begin
        found = 1'b1;
        break;
      end
    end
    check("credit_fill", int'(found), 1);
    repeat (10) @(negedge clk);
    #1;
    check("credit_stall_count", issued, MO);
    check("credit_stall_valid", int'(issue_valid), 0);
    #1 pulse_req = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("credit_one_more", issued, MO + 1);
    check("credit_stall_again", int'(issue_valid), 0);
    #1 mode = M_BP;
    check_run_end("run2", 1'b0);

    // Run 3: ideal datapath, aborted by reset mid-step, then auto-restart.
    @(negedge clk);
    #2 mode = M_IDEAL;
    push_run();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (int'(time_step) == 1 && int'(issue_addr) == 7) begin
        found = 1'b1;
        break;
      end
    end
    check("midrun_reached", int'(found), 1);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    exp_init.delete();
    exp_issue.delete();
    push_run();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    check_run_end("run3", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
